// File: rtl/pipe_tree_adder.sv
// pipe_tree_adder: pipelined signed N_IN-lane tree adder with packet accumulation,
// round/shift/saturate output conversion and valid/ready flow control.
module pipe_tree_adder #(
  parameter int unsigned N_IN    = 32,
  parameter int unsigned IN_W    = 36,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned SHIFT   = 12,
  parameter int unsigned ROUND   = 1,
  parameter int unsigned ACC_EXT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_last,
  input  logic [N_IN*IN_W-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat,
  output logic [15:0]          out_beats
);

  localparam int unsigned LOG2N = $clog2(N_IN);
  localparam int unsigned SUM_W = IN_W + LOG2N;
  localparam int unsigned ACC_W = SUM_W + ACC_EXT;
  // One extra bit so the rounding constant can never wrap the accumulator.
  localparam int unsigned R_W   = ACC_W + 1;
  localparam int unsigned RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [R_W-1:0] RND_C =
    (ROUND != 0 && SHIFT > 0) ? (R_W'(1) << RND_SH) : '0;
  localparam logic signed [R_W-1:0] Q_MAX = {{(R_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [R_W-1:0] Q_MIN = {{(R_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic advance;

  // Whole pipeline moves together; it only stalls when a result is parked at the output.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // Tree: level 0 is the unregistered input, level s registers N_IN>>s sums of IN_W+s bits.
  for (genvar s = 0; s <= LOG2N; s++) begin : g_st
    localparam int unsigned W = IN_W + s;
    localparam int unsigned N = N_IN >> s;
    logic signed [W-1:0] d [N];
    logic                v;
    logic                l;

    if (s == 0) begin : g_in
      for (genvar k = 0; k < N; k++) begin : g_lane
        assign d[k] = in_data[k*IN_W +: IN_W];
      end
      assign v = in_valid;
      assign l = in_last & in_valid;
    end else begin : g_reg
      // Valid/last tags of this tree level; they hold while stalled.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v <= 1'b0;
          l <= 1'b0;
        end else if (advance) begin
          v <= g_st[s-1].v;
          l <= g_st[s-1].l;
        end
      end

      for (genvar k = 0; k < N; k++) begin : g_add
        // Sign-extended pairwise sum of adjacent entries from the previous level.
        always_ff @(posedge clk) begin
          if (advance) begin
            d[k] <= W'(g_st[s-1].d[2*k]) + W'(g_st[s-1].d[2*k+1]);
          end
        end
      end
    end
  end

  logic signed [SUM_W-1:0] beat_sum;
  logic                    beat_v;
  logic                    beat_l;

  assign beat_sum = g_st[LOG2N].d[0];
  assign beat_v   = g_st[LOG2N].v;
  assign beat_l   = g_st[LOG2N].l;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic [15:0]             beats;
  logic [15:0]             beats_base;
  logic [15:0]             beats_nxt;
  logic                    open;
  logic                    done;

  // Next accumulator/beat count: restart from zero unless a packet is open.
  always_comb begin
    acc_nxt    = (open ? acc : '0) + ACC_W'(beat_sum);
    beats_base = open ? beats : 16'd0;
    beats_nxt  = (beats_base == 16'hFFFF) ? beats_base : beats_base + 16'd1;
  end

  // Accumulate stage; done flags a finished packet sitting in acc/beats.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc   <= '0;
      beats <= '0;
      open  <= 1'b0;
      done  <= 1'b0;
    end else if (advance) begin
      if (beat_v) begin
        acc   <= acc_nxt;
        beats <= beats_nxt;
        open  <= !beat_l;
        done  <= beat_l;
      end else begin
        done  <= 1'b0;
      end
    end
  end

  logic signed [R_W-1:0]   r;
  logic signed [R_W-1:0]   q;
  logic [OUT_W-1:0]        conv_data;
  logic                    conv_sat;

  // Round, arithmetic shift and clip the finished packet sum.
  always_comb begin
    r         = R_W'(acc) + RND_C;
    q         = r >>> SHIFT;
    conv_data = q[OUT_W-1:0];
    conv_sat  = 1'b0;
    if (q > Q_MAX) begin
      conv_data = Q_MAX[OUT_W-1:0];
      conv_sat  = 1'b1;
    end else if (q < Q_MIN) begin
      conv_data = Q_MIN[OUT_W-1:0];
      conv_sat  = 1'b1;
    end
  end

  // Output register: load on completion, drop on consume, hold while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_beats <= '0;
    end else if (advance && done) begin
      out_valid <= 1'b1;
      out_data  <= conv_data;
      out_sat   <= conv_sat;
      out_beats <= beats;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_tree_adder.sv
// tb_pipe_tree_adder: directed checks of pipe_tree_adder with default parameters
// plus a ROUND=0 instance fed the same stimulus.
module tb_pipe_tree_adder;
  localparam int unsigned N  = 32;
  localparam int unsigned W  = 36;
  localparam int unsigned OW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_last;
  logic [N*W-1:0]  in_data;
  logic            out_ready;
  logic            in_ready,  in_ready_t;
  logic            out_valid, out_valid_t;
  logic [OW-1:0]   out_data,  out_data_t;
  logic            out_sat,   out_sat_t;
  logic [15:0]     out_beats, out_beats_t;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipe_tree_adder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .out_beats(out_beats)
  );

  pipe_tree_adder #(.ROUND(0)) dut_trunc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_last(in_last), .in_data(in_data), .out_valid(out_valid_t),
    .out_ready(out_ready), .out_data(out_data_t), .out_sat(out_sat_t),
    .out_beats(out_beats_t)
  );

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] lanes(input longint others, input longint lane0);
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = W'(others);
    v[0 +: W] = W'(lane0);
    return v;
  endfunction

  // Present one beat at edge+1 and return at edge+1 after the accepting edge.
  task automatic send_beat(input logic [N*W-1:0] d, input logic last);
    logic acc;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int n = 0; n < 200; n++) begin
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) break;
      if (n == 199) check("send_timeout", 0, 1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic single(input string tag, input logic [N*W-1:0] d,
                        input longint exp_data, input longint exp_sat);
    int cyc;
    send_beat(d, 1'b1);
    wait_out(cyc);
    check({tag, "_data"}, longint'($signed(out_data)), exp_data);
    check({tag, "_sat"}, longint'(out_sat), exp_sat);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int exp_k;
    int tick;
    logic held;
    logic [OW+16-1:0] held_val;

    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; out_ready = 1'b1;
    #12;
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data",  longint'(out_data), 0);
    check("rst_out_beats", longint'(out_beats), 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", longint'(in_ready), 1);

    // Basic sum and latency.
    send_beat(lanes(4096, 4096), 1'b1);
    wait_out(cyc);
    check("lat_cycles", cyc, 6);
    check("basic_data", longint'($signed(out_data)), 32);
    check("basic_sat", longint'(out_sat), 0);
    check("basic_beats", longint'(out_beats), 1);
    @(posedge clk); #1;
    check("basic_drop", longint'(out_valid), 0);

    // Rounding, both instances see the same -32 sum.
    send_beat(lanes(-1, -1), 1'b1);
    wait_out(cyc);
    check("rnd_neg_data", longint'($signed(out_data)), 0);
    check("trunc_neg_data", longint'($signed(out_data_t)), -1);
    @(posedge clk); #1;
    single("rnd_half", lanes(0, 2048), 1, 0);

    // Saturation.
    single("sat_pos", lanes(64'sd1 <<< 30, 64'sd1 <<< 30), 32767, 1);
    single("sat_neg", lanes(-(64'sd1 <<< 30), -(64'sd1 <<< 30)), -32768, 1);

    // Multi-beat packet: an early output would show up fewer than 6 cycles after beat 3.
    send_beat(lanes(0, 4096), 1'b0);
    send_beat(lanes(0, 4096), 1'b0);
    send_beat(lanes(0, 4096), 1'b1);
    wait_out(cyc);
    check("multi_lat", cyc, 6);
    check("multi_data", longint'($signed(out_data)), 3);
    check("multi_beats", longint'(out_beats), 3);
    @(posedge clk); #1;

    // Backpressure with random out_ready.
    exp_k = 1;
    held = 1'b0;
    held_val = '0;
    fork
      begin
        @(posedge clk); #3;
        for (int k = 1; k <= 20; k++) begin
          logic a;
          in_valid = 1'b1;
          in_data  = lanes(0, longint'(k) * 4096);
          in_last  = 1'b1;
          for (int n = 0; n < 500; n++) begin
            a = in_ready;
            @(posedge clk); #3;
            if (a) break;
          end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      begin
        @(posedge clk);
        tick = 0;
        while (exp_k <= 20 && tick < 3000) begin
          #1 out_ready = 1'($urandom_range(0, 1));
          #1;
          check("bp_in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
          if (held) check("bp_hold", longint'({out_valid, out_data, out_beats}),
                          longint'({1'b1, held_val}));
          if (out_valid && out_ready) begin
            check("bp_data", longint'($signed(out_data)), exp_k);
            check("bp_beats", longint'(out_beats), 1);
            exp_k++;
          end
          held = out_valid && !out_ready;
          held_val = {out_data, out_beats};
          @(posedge clk);
          tick++;
        end
      end
    join
    check("bp_count", exp_k, 21);
    #1 out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    check("bp_no_extra", longint'(out_valid), 0);

    // Reset with a parked result and a partial packet in flight.
    out_ready = 1'b0;
    send_beat(lanes(0, 8192), 1'b1);
    send_beat(lanes(0, 4096), 1'b0);
    send_beat(lanes(0, 4096), 1'b0);
    repeat (8) begin @(posedge clk); #1; end
    check("pre_rst_valid", longint'(out_valid), 1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", longint'(out_valid), 0);
    check("mid_rst_data", longint'(out_data), 0);
    check("mid_rst_sat", longint'(out_sat), 0);
    check("mid_rst_beats", longint'(out_beats), 0);
    check("mid_rst_ready", longint'(in_ready), 1);
    @(negedge clk); reset = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    send_beat(lanes(0, 4096), 1'b1);
    wait_out(cyc);
    check("post_rst_data", longint'($signed(out_data)), 1);
    check("post_rst_beats", longint'(out_beats), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/pipe_tree_adder.md
Name: pipe_tree_adder

Overview:
- Parametrised, pipelined successor to the combinational 32-input fixed-point tree adder used in the convolution datapath.
- Sums N_IN signed lanes through a registered binary tree, with one register level per tree stage.
- Optionally accumulates several beats into one packet, then rounds, shifts and saturates to the output format.
- Uses a valid/ready handshake on both sides with full backpressure; sits between the MAC array and the result writer.

Parameters:
- N_IN, 32, number of lanes; power of two, at least 2; LOG2N = log2(N_IN).
- IN_W, 36, signed lane width.
- OUT_W, 16, signed output width.
- SHIFT, 12, arithmetic right shift applied to the accumulated sum; 0 is legal.
- ROUND, 1, 1 = round half up before the shift; 0 = truncate toward minus infinity.
- ACC_EXT, 8, guard bits added to the accumulator.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data and in_last are valid this cycle.
- in_ready  out  1  block accepts a beat this cycle.
- in_last  in  1  this beat closes the current packet.
- in_data  in  N_IN*IN_W  packed lanes; lane k occupies bits [k*IN_W +: IN_W], two's complement.
- out_valid  out  1  out_data, out_sat and out_beats are valid.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  OUT_W  rounded, shifted, saturated packet sum.
- out_sat  out  1  out_data was clipped.
- out_beats  out  16  number of beats in the packet; saturates at 65535.

Behaviour:
- Widths: tree stage s (1..LOG2N) registers IN_W+s bits and sign-extends every add. SUM_W = IN_W+LOG2N. Accumulator ACC_W = SUM_W+ACC_EXT. No intermediate truncation.
- Advance rule: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 0, every pipeline register holds, including the per-stage valid and last tags.
  - A beat is accepted on in_valid && in_ready.
  - in_data is ignored when in_valid = 0; the bubble propagates with valid = 0.
- Tree:
  - Stage 1 registers the N_IN/2 pairwise sums of adjacent lanes (0+1, 2+3, ...).
  - Each later stage adds adjacent pairs of the previous stage.
  - Stage LOG2N holds the beat sum.
- Accumulate stage: when the stage LOG2N tag is valid and advance = 1:
  - acc = (open ? acc : 0) + beat_sum.
  - beats = (open ? beats : 0) + 1, saturating at 65535.
  - If tag last: open = 0 and the output register is loaded. Otherwise open = 1.
- Output conversion, combinational from the accumulate result into the output register:
  - r = acc + (ROUND && SHIFT>0 ? 2^(SHIFT-1) : 0), then q = r >>> SHIFT.
  - If q > 2^(OUT_W-1)-1: out_data = max, out_sat = 1. If q < -2^(OUT_W-1): out_data = min, out_sat = 1. Otherwise out_data = q[OUT_W-1:0], out_sat = 0.
- Output register:
  - out_valid is set when a last beat completes.
  - out_valid is cleared on out_ready unless a new completion occurs in the same cycle; in that case the new result is loaded and out_valid stays 1.
  - out_data, out_sat and out_beats are stable while out_valid = 1 and out_ready = 0.
- Latency: a last beat accepted at edge t with no stall gives out_valid = 1 after edge t+LOG2N+1, i.e. 6 cycles for N_IN = 32. Throughput is one beat per cycle.
- Simultaneous events:
  - out_ready and a completing packet in the same cycle → the old result is consumed and the new one is loaded, with no bubble.
  - in_last with in_valid = 0 is ignored.
- Reset (asynchronous, any time, including mid-packet or mid-stall):
  - All valid tags = 0, open = 0, acc = 0, beats = 0.
  - out_valid = 0, out_data = 0, out_sat = 0, out_beats = 0.
  - in_ready = 1 after release.
  - A partial packet is discarded; the next packet starts from zero.

Test Plan:
- Default parameters: all 32 lanes = 4096, in_last = 1 → 6 cycles later out_valid = 1, out_data = 32, out_sat = 0, out_beats = 1.
- Rounding:
  - All lanes = -1 → sum -32; out_data = 0 with ROUND = 1.
  - Same stimulus with ROUND = 0 → out_data = -1.
  - Lane0 = 2048, others 0, ROUND = 1 → out_data = 1.
- Saturation:
  - All lanes = 2^30 → out_data = 32767, out_sat = 1.
  - All lanes = -2^30 → out_data = -32768, out_sat = 1.
- Multi-beat: three consecutive beats with lane0 = 4096, others 0, in_last only on the third → a single result out_data = 3, out_beats = 3, with no output after beats 1 and 2.
- Backpressure: stream 20 single-beat packets with lane0 = k*4096 (k = 1..20) while out_ready toggles 0/1 pseudo-randomly.
  - in_ready follows the advance rule.
  - Results appear in order as 1..20, with none lost or duplicated.
  - The output is held stable while stalled.
- Reset mid-operation: assert reset with a 2-beat partial packet and a full pipeline → all outputs zero immediately. After release, a single beat with lane0 = 4096 yields out_data = 1, out_beats = 1.
